led_display_panel_rx: RTL and testbench
=======================================

# led_display_panel_rx

Receive-side model of the HUB75-style LED panel link: samples the serial bus produced by the display driver PHY (bit clock, latch, row address, top/bottom RGB data), deserialises one double-row per latch and replays it as a pixel stream with valid/ready handshake. Sits in the verification/loopback path behind the driver PHY so captured frames can be compared against the pattern generator output. It is fully synthesizable so it can also run on-board against the physical pins.

## Interface
- SYS_CLK_FREQ, 12_500_000: clk_in frequency (Hz).
- NUM_ROW_PIXELS, 32: panel rows; must be even; row address width is $clog2(NUM_ROW_PIXELS/2).
- NUM_COL_PIXELS, 64: panel columns; bits per latch per half.
- BCLK_FREQ, 2_000_000: maximum incoming bit clock; elaboration error if BCLK_FREQ > SYS_CLK_FREQ/4.

Ports:
- clk_in  in  1  system clock; single clock domain.
- n_reset_in  in  1  asynchronous, active-low reset.
- bclk_in  in  1  panel bit clock (asynchronous to clk_in).
- lat_in  in  1  latch strobe, active high.
- addr_in  in  $clog2(NUM_ROW_PIXELS/2)  row address.
- rgb_top_in  in  3  {r,g,b} for upper half.
- rgb_bot_in  in  3  {r,g,b} for lower half.
- pix_valid_out  out  1  pixel stream valid.
- pix_ready_in  in  1  pixel stream ready.
- pix_x_out  out  $clog2(NUM_COL_PIXELS)  column.
- pix_y_out  out  $clog2(NUM_ROW_PIXELS)  row.
- pix_rgb_out  out  3  {r,g,b}.
- overrun_out  out  1  sticky: latch arrived while drain busy.
- length_err_out  out  1  sticky: latch with bit count != NUM_COL_PIXELS.
- row_count_out  out  16  rows accepted, wraps at 2^16.

## Operation
- All bus inputs pass through a 2-FF synchroniser; bclk and lat get a registered copy for rising-edge detection. Data/addr are taken from the same synchroniser stage as the edge, so they align with the edge.
- Capture side: on each synced bclk rising edge, rgb_top/rgb_bot shift into capture registers; first bit after a latch is column 0. Column counter saturates at NUM_COL_PIXELS; further bits are discarded.
- On synced lat rising edge:
  - count == NUM_COL_PIXELS and drain IDLE: copy capture regs + addr to hold regs, increment row_count_out, start drain.
  - count != NUM_COL_PIXELS: set length_err_out, drop row.
  - drain busy (valid count): set overrun_out, drop row.
  - Column counter clears in all cases.
- Simultaneous bclk and lat edges in the same cycle: the bit is shifted first, then the latch is evaluated including that bit.
- Drain FSM: IDLE -> TOP -> BOT -> IDLE. TOP emits x=0..NUM_COL_PIXELS-1, y=addr; BOT emits x=0..NUM_COL_PIXELS-1, y=addr+NUM_ROW_PIXELS/2. x advances only on pix_valid_out & pix_ready_in; TOP->BOT on accepted x=max in TOP; BOT->IDLE on accepted x=max in BOT.
- Capture continues during drain (double buffered).
- Sticky flags clear only on reset.

## Timing
- Reset values: pix_valid_out 0, pix_x/y/rgb 0, overrun 0, length_err 0, row_count 0, FSM IDLE, capture/hold regs 0, synchronisers 0.
- Reset mid-drain or mid-row discards all partial data; the first row after reset needs a full NUM_COL_PIXELS bits then a latch.
- Latency: pix_valid_out rises on the 4th clk_in rising edge after lat_in is first sampled high, provided the drain is IDLE.
- Throughput: 1 pixel/cycle with pix_ready_in held high; 2*NUM_COL_PIXELS cycles per row. pix_* outputs are stable while valid & !ready.
- bclk_in and lat_in high and low phases must each be >= 2 clk_in periods.

## Structure
- led_display_pkg: rgb_t (3-bit packed {r,g,b}), drain state enum, shared NUM_ROW/NUM_COL defaults.
- Sub-module led_display_sync: parameterised-width 2-FF synchroniser, async active-low reset, reusable by other blocks.

## Test plan
- Reset: hold n_reset_in low 100 ns -> all outputs 0, pix_valid_out low.
- Single row: 64 bclks, top=3'b100 and bot=3'b001 at x=5 (0 elsewhere), addr=3, latch -> 128 pixels; (5,3)=100, (5,19)=001, others 000; row_count_out=1.
- Backpressure: toggle pix_ready_in 50% random -> identical pixel sequence; no skips or duplicates.
- Short row: 63 bclks then latch -> length_err_out=1, no pixels emitted; next full row is received correctly.
- Overrun: second full row latched while first is draining with pix_ready_in=0 -> overrun_out=1; only the first row emitted; row_count_out=1.
- Reset mid-drain after 10 accepted pixels -> pix_valid_out=0 next cycle; a subsequent full row drains from x=0.

Source files
------------

// File: rtl/led_display_panel_rx_pkg.sv
// Shared types and default geometry for the LED panel receive path.
package led_display_panel_rx_pkg;

    // One pixel colour, packed {r,g,b}.
    typedef logic [2:0] rgb_t;

    // Drain sequencer: upper half-row first, then lower half-row.
    typedef enum logic [1:0] {
        DRAIN_IDLE = 2'd0,
        DRAIN_TOP  = 2'd1,
        DRAIN_BOT  = 2'd2
    } drain_state_t;

    localparam int DEF_NUM_ROW_PIXELS = 32;
    localparam int DEF_NUM_COL_PIXELS = 64;

endpackage

// File: rtl/led_display_panel_rx_if.sv
// Pixel stream carrying one replayed pixel per accepted transfer.
//
// Handshake: the master raises pix_valid_out with pix_x/y/rgb stable and keeps
// them unchanged until a cycle where pix_valid_out & pix_ready_in are both high
// at the rising clock edge; that edge is the transfer. The slave may change
// pix_ready_in freely and may depend combinationally on nothing from the master.
interface led_display_panel_rx_if #(
    parameter int X_W = 6,
    parameter int Y_W = 5
) ();
    logic           pix_valid_out;
    logic           pix_ready_in;
    logic [X_W-1:0] pix_x_out;
    logic [Y_W-1:0] pix_y_out;
    logic [2:0]     pix_rgb_out;

    modport master (
        output pix_valid_out, pix_x_out, pix_y_out, pix_rgb_out,
        input  pix_ready_in
    );

    modport slave (
        input  pix_valid_out, pix_x_out, pix_y_out, pix_rgb_out,
        output pix_ready_in
    );
endinterface

// File: rtl/led_display_panel_rx_sync.sv
// Generic 2-FF synchroniser for a bundle of asynchronous inputs.
module led_display_panel_rx_sync #(
    parameter int W = 1
) (
    input  logic         clk_in,
    input  logic         n_reset_in,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q_out
);

    logic [W-1:0] meta_q;

    // Two flops in series; only the second stage is used downstream.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            meta_q <= '0;
            q_out  <= '0;
        end else begin
            meta_q <= d_in;
            q_out  <= meta_q;
        end
    end

endmodule

// File: rtl/led_display_panel_rx.sv
// Receives the HUB75-style serial panel bus, captures one double-row per
// latch and replays it as a pixel stream (upper half-row, then lower).
module led_display_panel_rx
    import led_display_panel_rx_pkg::*;
#(
    parameter int SYS_CLK_FREQ   = 12_500_000,
    parameter int NUM_ROW_PIXELS = DEF_NUM_ROW_PIXELS,
    parameter int NUM_COL_PIXELS = DEF_NUM_COL_PIXELS,
    parameter int BCLK_FREQ      = 2_000_000,
    localparam int AW = $clog2(NUM_ROW_PIXELS / 2),
    localparam int XW = $clog2(NUM_COL_PIXELS),
    localparam int YW = $clog2(NUM_ROW_PIXELS)
) (
    input  logic                  clk_in,
    input  logic                  n_reset_in,
    input  logic                  bclk_in,
    input  logic                  lat_in,
    input  logic [AW-1:0]         addr_in,
    input  logic [2:0]            rgb_top_in,
    input  logic [2:0]            rgb_bot_in,
    led_display_panel_rx_if.master pix,
    output logic                  overrun_out,
    output logic                  length_err_out,
    output logic [15:0]           row_count_out,
    output drain_state_t          drain_state_out
);

    localparam int CW = $clog2(NUM_COL_PIXELS + 1);
    localparam int SW = AW + 8;
    localparam logic [CW-1:0] COL_CNT = CW'(NUM_COL_PIXELS);
    localparam logic [XW-1:0] X_MAX   = XW'(NUM_COL_PIXELS - 1);
    localparam logic [YW-1:0] Y_HALF  = YW'(NUM_ROW_PIXELS / 2);

    if (BCLK_FREQ > SYS_CLK_FREQ / 4) begin : g_bclk_chk
        $error("BCLK_FREQ must not exceed SYS_CLK_FREQ/4");
    end
    if ((NUM_ROW_PIXELS % 2) != 0) begin : g_row_chk
        $error("NUM_ROW_PIXELS must be even");
    end

    logic [SW-1:0] sync_q;
    logic          s_bclk, s_lat;
    logic [AW-1:0] s_addr;
    rgb_t          s_rgb_top, s_rgb_bot;

    led_display_panel_rx_sync #(.W(SW)) u_sync (
        .clk_in     (clk_in),
        .n_reset_in (n_reset_in),
        .d_in       ({bclk_in, lat_in, addr_in, rgb_top_in, rgb_bot_in}),
        .q_out      (sync_q)
    );
    assign {s_bclk, s_lat, s_addr, s_rgb_top, s_rgb_bot} = sync_q;

    logic          bclk_d, lat_d;
    logic          bclk_rise, lat_rise;
    logic [CW-1:0] cnt_q, cnt_nxt;
    rgb_t          cap_top_q [NUM_COL_PIXELS];
    rgb_t          cap_bot_q [NUM_COL_PIXELS];
    rgb_t          cap_top_nxt [NUM_COL_PIXELS];
    rgb_t          cap_bot_nxt [NUM_COL_PIXELS];
    rgb_t          hold_top [NUM_COL_PIXELS];
    rgb_t          hold_bot [NUM_COL_PIXELS];
    logic [AW-1:0] hold_addr;
    logic          start_q;
    logic          busy;
    drain_state_t  state_q, state_nxt;
    logic [XW-1:0] x_q;
    logic          accept;

    assign bclk_rise = s_bclk & ~bclk_d;
    assign lat_rise  = s_lat & ~lat_d;
    // A row handed over but not yet started still owns the hold registers.
    assign busy      = start_q | (state_q != DRAIN_IDLE);
    assign accept    = pix.pix_valid_out & pix.pix_ready_in;
    assign drain_state_out = state_q;

    // Capture view including this cycle's bit, so a same-cycle latch sees it.
    always_comb begin
        cap_top_nxt = cap_top_q;
        cap_bot_nxt = cap_bot_q;
        cnt_nxt     = cnt_q;
        if (bclk_rise && (cnt_q < COL_CNT)) begin
            cap_top_nxt[cnt_q[XW-1:0]] = s_rgb_top;
            cap_bot_nxt[cnt_q[XW-1:0]] = s_rgb_bot;
            cnt_nxt                    = cnt_q + CW'(1);
        end
    end

    // Capture registers, latch evaluation, hand-over to hold and status flags.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            bclk_d         <= 1'b0;
            lat_d          <= 1'b0;
            cnt_q          <= '0;
            cap_top_q      <= '{default: '0};
            cap_bot_q      <= '{default: '0};
            hold_top       <= '{default: '0};
            hold_bot       <= '{default: '0};
            hold_addr      <= '0;
            start_q        <= 1'b0;
            row_count_out  <= '0;
            overrun_out    <= 1'b0;
            length_err_out <= 1'b0;
        end else begin
            bclk_d    <= s_bclk;
            lat_d     <= s_lat;
            cap_top_q <= cap_top_nxt;
            cap_bot_q <= cap_bot_nxt;
            cnt_q     <= cnt_nxt;
            start_q   <= 1'b0;
            if (lat_rise) begin
                cnt_q <= '0;
                if (cnt_nxt != COL_CNT) begin
                    length_err_out <= 1'b1;
                end else if (busy) begin
                    overrun_out <= 1'b1;
                end else begin
                    hold_top      <= cap_top_nxt;
                    hold_bot      <= cap_bot_nxt;
                    hold_addr     <= s_addr;
                    row_count_out <= row_count_out + 16'd1;
                    start_q       <= 1'b1;
                end
            end
        end
    end

    // Drain state and column counter; the column moves only on a transfer.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q <= DRAIN_IDLE;
            x_q     <= '0;
        end else begin
            state_q <= state_nxt;
            if (accept) begin
                x_q <= (x_q == X_MAX) ? '0 : x_q + XW'(1);
            end
        end
    end

    // Next drain state.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            DRAIN_IDLE: if (start_q)                state_nxt = DRAIN_TOP;
            DRAIN_TOP:  if (accept && x_q == X_MAX) state_nxt = DRAIN_BOT;
            DRAIN_BOT:  if (accept && x_q == X_MAX) state_nxt = DRAIN_IDLE;
            default:                                state_nxt = DRAIN_IDLE;
        endcase
    end

    // Pixel outputs decoded from state; all zero while idle.
    always_comb begin
        pix.pix_valid_out = 1'b0;
        pix.pix_x_out     = '0;
        pix.pix_y_out     = '0;
        pix.pix_rgb_out   = '0;
        case (state_q)
            DRAIN_TOP: begin
                pix.pix_valid_out = 1'b1;
                pix.pix_x_out     = x_q;
                pix.pix_y_out     = YW'(hold_addr);
                pix.pix_rgb_out   = hold_top[x_q];
            end
            DRAIN_BOT: begin
                pix.pix_valid_out = 1'b1;
                pix.pix_x_out     = x_q;
                pix.pix_y_out     = YW'(hold_addr) + Y_HALF;
                pix.pix_rgb_out   = hold_bot[x_q];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_led_display_panel_rx.sv
// Bench for led_display_panel_rx: drives the serial panel bus, predicts the
// replayed pixel stream into a queue and checks every transfer against it.
module tb_led_display_panel_rx;
  localparam int NCOL = 64;
  localparam int NROW = 32;

  logic        clk_in = 1'b0;
  logic        n_reset_in = 1'b0;
  logic        bclk_in = 1'b0;
  logic        lat_in = 1'b0;
  logic [3:0]  addr_in = '0;
  logic [2:0]  rgb_top_in = '0;
  logic [2:0]  rgb_bot_in = '0;
  logic        overrun_out;
  logic        length_err_out;
  logic [15:0] row_count_out;
  logic [1:0]  drain_state;

  led_display_panel_rx_if #(.X_W(6), .Y_W(5)) pix_if ();

  led_display_panel_rx dut (
    .clk_in          (clk_in),
    .n_reset_in      (n_reset_in),
    .bclk_in         (bclk_in),
    .lat_in          (lat_in),
    .addr_in         (addr_in),
    .rgb_top_in      (rgb_top_in),
    .rgb_bot_in      (rgb_bot_in),
    .pix             (pix_if),
    .overrun_out     (overrun_out),
    .length_err_out  (length_err_out),
    .row_count_out   (row_count_out),
    .drain_state_out (drain_state)
  );

  // clock / reset: 12.5 MHz system clock
  always #40 clk_in = ~clk_in;

  int          n_compared = 0;
  int          n_mismatched = 0;
  int          n_accepted = 0;
  int          ready_mode = 0;  // 0 always ready, 1 random 50%, 2 never ready
  logic [13:0] exp_q[$];        // {x[5:0], y[4:0], rgb[2:0]}
  logic [2:0]  row_top [NCOL];
  logic [2:0]  row_bot [NCOL];
  logic [3:0]  row_addr;

  // ready driver, updated just after each rising edge
  initial begin
    pix_if.pix_ready_in = 1'b1;
    forever begin
      @(posedge clk_in);
      #1;
      case (ready_mode)
        0: pix_if.pix_ready_in = 1'b1;
        1: pix_if.pix_ready_in = 1'($urandom_range(0, 1));
        default: pix_if.pix_ready_in = 1'b0;
      endcase
    end
  end

  // scoreboard: a transfer is valid & ready at mid-cycle, taken at the next edge
  always @(negedge clk_in) begin
    if (n_reset_in && pix_if.pix_valid_out && pix_if.pix_ready_in) begin
      logic [13:0] got, want;
      got = {pix_if.pix_x_out, pix_if.pix_y_out, pix_if.pix_rgb_out};
      n_compared++;
      n_accepted++;
      if (exp_q.size() == 0) begin
        n_mismatched++;
        $display("FAIL pixel_unexpected got x=%0d y=%0d rgb=%b required no pixel",
                 got[13:8], got[7:3], got[2:0]);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_mismatched++;
          $display("FAIL pixel got x=%0d y=%0d rgb=%b required x=%0d y=%0d rgb=%b",
                   got[13:8], got[7:3], got[2:0], want[13:8], want[7:3], want[2:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic apply_reset();
    n_reset_in = 1'b0;
    bclk_in = 1'b0;
    lat_in = 1'b0;
    rgb_top_in = '0;
    rgb_bot_in = '0;
    addr_in = '0;
    exp_q.delete();
    #100;
    @(posedge clk_in);
    #1;
    n_reset_in = 1'b1;
    wait_clks(2);
  endtask

  task automatic fill_random_row();
    for (int i = 0; i < NCOL; i++) begin
      row_top[i] = 3'($urandom_range(0, 7));
      row_bot[i] = 3'($urandom_range(0, 7));
    end
    row_addr = 4'($urandom_range(0, 15));
  endtask

  task automatic send_bits(input int nbits);
    addr_in = row_addr;
    for (int i = 0; i < nbits; i++) begin
      rgb_top_in = row_top[i];
      rgb_bot_in = row_bot[i];
      bclk_in = 1'b1;
      wait_clks(3);
      bclk_in = 1'b0;
      wait_clks(3);
    end
  endtask

  task automatic send_latch();
    lat_in = 1'b1;
    wait_clks(3);
    lat_in = 1'b0;
    wait_clks(3);
  endtask

  task automatic push_row();
    for (int i = 0; i < NCOL; i++)
      exp_q.push_back({6'(i), 5'(row_addr), row_top[i]});
    for (int i = 0; i < NCOL; i++)
      exp_q.push_back({6'(i), 5'(row_addr) + 5'(NROW / 2), row_bot[i]});
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || drain_state != 2'd0) && n < budget) begin
      @(posedge clk_in);
      n++;
    end
    #1;
    n_compared++;
    if (n >= budget) begin
      n_mismatched++;
      $display("FAIL drain_timeout got %0d pixels outstanding required 0 within %0d cycles",
               exp_q.size(), budget);
    end
  endtask

  // tests
  task automatic test_reset();
    apply_reset();
    n_compared += 8;
    if (pix_if.pix_valid_out !== 1'b0) begin n_mismatched++; $display("FAIL reset_valid got %b required 0", pix_if.pix_valid_out); end
    if (pix_if.pix_x_out !== 6'd0) begin n_mismatched++; $display("FAIL reset_x got %0d required 0", pix_if.pix_x_out); end
    if (pix_if.pix_y_out !== 5'd0) begin n_mismatched++; $display("FAIL reset_y got %0d required 0", pix_if.pix_y_out); end
    if (pix_if.pix_rgb_out !== 3'd0) begin n_mismatched++; $display("FAIL reset_rgb got %b required 000", pix_if.pix_rgb_out); end
    if (overrun_out !== 1'b0) begin n_mismatched++; $display("FAIL reset_overrun got %b required 0", overrun_out); end
    if (length_err_out !== 1'b0) begin n_mismatched++; $display("FAIL reset_length_err got %b required 0", length_err_out); end
    if (row_count_out !== 16'd0) begin n_mismatched++; $display("FAIL reset_row_count got %0d required 0", row_count_out); end
    if (drain_state !== 2'd0) begin n_mismatched++; $display("FAIL reset_state got %0d required 0", drain_state); end
  endtask

  task automatic test_single_row();
    int n;
    apply_reset();
    ready_mode = 0;
    for (int i = 0; i < NCOL; i++) begin
      row_top[i] = (i == 5) ? 3'b100 : 3'b000;
      row_bot[i] = (i == 5) ? 3'b001 : 3'b000;
    end
    row_addr = 4'd3;
    send_bits(NCOL);
    push_row();
    lat_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    n_compared++;
    if (pix_if.pix_valid_out !== 1'b0) begin n_mismatched++; $display("FAIL latency_early got valid=%b after 3 edges required 0", pix_if.pix_valid_out); end
    @(posedge clk_in);
    #1;
    n_compared++;
    if (pix_if.pix_valid_out !== 1'b1) begin n_mismatched++; $display("FAIL latency got valid=%b after 4 edges required 1", pix_if.pix_valid_out); end
    n = 0;
    while (pix_if.pix_valid_out && n < 1000) begin
      n++;
      @(posedge clk_in);
      #1;
    end
    n_compared++;
    if (n != 2 * NCOL) begin n_mismatched++; $display("FAIL throughput got %0d valid cycles required %0d", n, 2 * NCOL); end
    lat_in = 1'b0;
    wait_clks(3);
    wait_drain(500);
    n_compared++;
    if (row_count_out !== 16'd1) begin n_mismatched++; $display("FAIL single_row_count got %0d required 1", row_count_out); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    fill_random_row();
    ready_mode = 1;
    send_bits(NCOL);
    push_row();
    send_latch();
    wait_drain(3000);
    ready_mode = 0;
    n_compared++;
    if (row_count_out !== 16'd1) begin n_mismatched++; $display("FAIL backpressure_count got %0d required 1", row_count_out); end
  endtask

  task automatic test_short_row();
    apply_reset();
    fill_random_row();
    send_bits(NCOL - 1);
    send_latch();
    wait_clks(10);
    n_compared += 3;
    if (length_err_out !== 1'b1) begin n_mismatched++; $display("FAIL short_length_err got %b required 1", length_err_out); end
    if (row_count_out !== 16'd0) begin n_mismatched++; $display("FAIL short_row_count got %0d required 0", row_count_out); end
    if (drain_state !== 2'd0) begin n_mismatched++; $display("FAIL short_state got %0d required 0", drain_state); end
    fill_random_row();
    send_bits(NCOL);
    push_row();
    send_latch();
    wait_drain(500);
    n_compared += 2;
    if (row_count_out !== 16'd1) begin n_mismatched++; $display("FAIL short_next_count got %0d required 1", row_count_out); end
    if (length_err_out !== 1'b1) begin n_mismatched++; $display("FAIL short_sticky got %b required 1", length_err_out); end
  endtask

  task automatic test_overrun();
    apply_reset();
    ready_mode = 2;
    fill_random_row();
    send_bits(NCOL);
    push_row();
    send_latch();
    fill_random_row();
    send_bits(NCOL);
    send_latch();
    wait_clks(5);
    n_compared += 3;
    if (overrun_out !== 1'b1) begin n_mismatched++; $display("FAIL overrun_flag got %b required 1", overrun_out); end
    if (row_count_out !== 16'd1) begin n_mismatched++; $display("FAIL overrun_count got %0d required 1", row_count_out); end
    if (length_err_out !== 1'b0) begin n_mismatched++; $display("FAIL overrun_length_err got %b required 0", length_err_out); end
    ready_mode = 0;
    wait_drain(500);
    wait_clks(20);
    n_compared++;
    if (row_count_out !== 16'd1) begin n_mismatched++; $display("FAIL overrun_final_count got %0d required 1", row_count_out); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    fill_random_row();
    send_bits(NCOL - 1);
    rgb_top_in = row_top[NCOL-1];
    rgb_bot_in = row_bot[NCOL-1];
    push_row();
    bclk_in = 1'b1;
    lat_in = 1'b1;
    wait_clks(3);
    bclk_in = 1'b0;
    lat_in = 1'b0;
    wait_clks(3);
    n_compared += 2;
    if (row_count_out !== 16'd1) begin n_mismatched++; $display("FAIL simul_count got %0d required 1", row_count_out); end
    if (length_err_out !== 1'b0) begin n_mismatched++; $display("FAIL simul_length_err got %b required 0", length_err_out); end
    wait_drain(500);
  endtask

  task automatic test_reset_mid_drain();
    int base, guard;
    apply_reset();
    ready_mode = 0;
    fill_random_row();
    send_bits(NCOL);
    push_row();
    base = n_accepted;
    lat_in = 1'b1;
    guard = 0;
    while (n_accepted < base + 10 && guard < 200) begin
      @(posedge clk_in);
      guard++;
    end
    #1;
    n_compared++;
    if (guard >= 200) begin n_mismatched++; $display("FAIL mid_drain_wait got %0d accepted required 10", n_accepted - base); end
    n_reset_in = 1'b0;
    lat_in = 1'b0;
    exp_q.delete();
    @(posedge clk_in);
    #1;
    n_compared += 2;
    if (pix_if.pix_valid_out !== 1'b0) begin n_mismatched++; $display("FAIL mid_reset_valid got %b required 0", pix_if.pix_valid_out); end
    if (row_count_out !== 16'd0) begin n_mismatched++; $display("FAIL mid_reset_count got %0d required 0", row_count_out); end
    #100;
    @(posedge clk_in);
    #1;
    n_reset_in = 1'b1;
    wait_clks(2);
    fill_random_row();
    send_bits(NCOL);
    push_row();
    send_latch();
    wait_drain(500);
    n_compared++;
    if (row_count_out !== 16'd1) begin n_mismatched++; $display("FAIL post_reset_count got %0d required 1", row_count_out); end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_backpressure();
    test_short_row();
    test_overrun();
    test_simultaneous();
    test_reset_mid_drain();
    wait_clks(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
